// File: rtl/clk_synth_pkg.sv
// Shared types and constants for the NCO-based carrier synthesiser.
package clk_synth_pkg;

   localparam int SETTLE_W  = 16;
   localparam int MAX_CH    = 8;
   localparam int CH_IDX_W  = $clog2(MAX_CH);
   localparam int MAX_ACC_W = 64;

   typedef enum logic [1:0] {
      ST_RESET,
      ST_IDLE,
      ST_APPLY
   } cfg_state_t;

   // A tuning word is usable only below Nyquist, i.e. with the accumulator MSB clear.
   function automatic logic ftw_valid(input logic [MAX_ACC_W-1:0] ftw, input int acc_w);
      return (ftw >> (acc_w - 1)) == '0;
   endfunction

endpackage

// File: rtl/clk_synth_channel.sv
// One NCO channel: phase accumulator, tuning word, settle counter and lock flag.
module clk_synth_channel
   import clk_synth_pkg::*;
#(
   parameter int               ACC_W         = 32,
   parameter logic [ACC_W-1:0] DEFAULT_FTW   = {2'b01, {(ACC_W-2){1'b0}}},
   parameter int               SETTLE_CYCLES = 64
)(
   input  logic             refclk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             load,
   input  logic [ACC_W-1:0] load_ftw,
   input  logic [ACC_W-1:0] load_phase,
   output logic             outclk,
   output logic             ch_locked
);

   localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_CYCLES[SETTLE_W-1:0];
   localparam logic [SETTLE_W-1:0] CNT_ONE     = {{(SETTLE_W-1){1'b0}}, 1'b1};

   logic [ACC_W-1:0]    acc;
   logic [ACC_W-1:0]    ftw;
   logic [SETTLE_W-1:0] settle_cnt;
   logic                locked_q;

   // Retune wins over everything; a disabled channel sits at phase zero waiting to resettle,
   // and a zero tuning word freezes the phase and never reports lock.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         acc        <= '0;
         ftw        <= DEFAULT_FTW;
         settle_cnt <= SETTLE_LOAD;
         locked_q   <= 1'b0;
      end else if (load) begin
         ftw        <= load_ftw;
         acc        <= en ? load_phase : '0;
         settle_cnt <= SETTLE_LOAD;
         locked_q   <= 1'b0;
      end else if (!en) begin
         acc        <= '0;
         settle_cnt <= SETTLE_LOAD;
         locked_q   <= 1'b0;
      end else if (ftw != '0) begin
         acc <= acc + ftw;
         if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - CNT_ONE;
            if (settle_cnt == CNT_ONE) begin
               locked_q <= 1'b1;
            end
         end
      end else begin
         locked_q <= 1'b0;
      end
   end

   assign outclk    = acc[ACC_W-1];
   assign ch_locked = locked_q;

endmodule

// File: rtl/clk_synth_nco.sv
// Multi-channel retunable carrier synthesiser: config FSM, channel decode, lock aggregation.
module clk_synth_nco
   import clk_synth_pkg::*;
#(
   parameter int               NUM_CH        = 2,
   parameter int               ACC_W         = 32,
   parameter logic [ACC_W-1:0] DEFAULT_FTW   = {2'b01, {(ACC_W-2){1'b0}}},
   parameter int               SETTLE_CYCLES = 64
)(
   input  logic                refclk,
   input  logic                rst_n,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [CH_IDX_W-1:0] cfg_ch,
   input  logic [ACC_W-1:0]    cfg_ftw,
   input  logic [ACC_W-1:0]    cfg_phase,
   output logic                cfg_err,
   input  logic [NUM_CH-1:0]   ch_en,
   output logic [NUM_CH-1:0]   outclk,
   output logic [NUM_CH-1:0]   ch_locked,
   output logic                locked
);

   cfg_state_t             state;
   cfg_state_t             state_next;
   logic                   handshake;
   logic [CH_IDX_W-1:0]    cap_ch;
   logic [ACC_W-1:0]       cap_ftw;
   logic [ACC_W-1:0]       cap_phase;
   logic                   cap_ok;
   logic                   cfg_ok;
   logic [MAX_ACC_W-1:0]   cfg_ftw_ext;
   logic                   apply_active;
   logic [NUM_CH-1:0]      apply;
   logic                   locked_q;

   // Config FSM state register; reset parks it in RESET so cfg_ready stays low until release.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_RESET;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake outputs: IDLE accepts, APPLY is a one-cycle busy slot.
   always_comb begin
      state_next = state;
      cfg_ready  = 1'b0;
      cfg_err    = 1'b0;
      unique case (state)
         ST_RESET: begin
            state_next = ST_IDLE;
         end
         ST_IDLE: begin
            cfg_ready = 1'b1;
            if (cfg_valid) begin
               state_next = ST_APPLY;
            end
         end
         ST_APPLY: begin
            cfg_err    = !cap_ok;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_RESET;
         end
      endcase
   end

   assign handshake = cfg_valid & cfg_ready;

   // Widen the incoming tuning word so the shared validity check can see it.
   always_comb begin
      cfg_ftw_ext              = '0;
      cfg_ftw_ext[ACC_W-1:0]   = cfg_ftw;
   end

   assign cfg_ok = (int'(cfg_ch) < NUM_CH) && ftw_valid(cfg_ftw_ext, ACC_W);

   // Capture the request at the handshake so the channel sees stable values during APPLY.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         cap_ch    <= '0;
         cap_ftw   <= '0;
         cap_phase <= '0;
         cap_ok    <= 1'b0;
      end else if (handshake) begin
         cap_ch    <= cfg_ch;
         cap_ftw   <= cfg_ftw;
         cap_phase <= cfg_phase;
         cap_ok    <= cfg_ok;
      end
   end

   assign apply_active = (state == ST_APPLY) && cap_ok;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign apply[g] = apply_active && (int'(cap_ch) == g);

      clk_synth_channel #(
         .ACC_W         (ACC_W),
         .DEFAULT_FTW   (DEFAULT_FTW),
         .SETTLE_CYCLES (SETTLE_CYCLES)
      ) u_ch (
         .refclk     (refclk),
         .rst_n      (rst_n),
         .en         (ch_en[g]),
         .load       (apply[g]),
         .load_ftw   (cap_ftw),
         .load_phase (cap_phase),
         .outclk     (outclk[g]),
         .ch_locked  (ch_locked[g])
      );
   end

   // Global lock: something is running and every running channel has settled.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         locked_q <= 1'b0;
      end else begin
         locked_q <= (|ch_en) && (&(ch_locked | ~ch_en));
      end
   end

   assign locked = locked_q;

endmodule
